// File: rtl/axi_stream_bus_pkg.sv
// Shared widths, stream/register-bus types, register map and FSM state type
// for the destination-MAC AXI-Stream filter.
package axi_stream_bus_pkg;

   localparam int AXIS_DATA_W = 64;
   localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
   localparam int AXIS_USER_W = 1;
   localparam int REG_ADDR_W  = 4;
   localparam int REG_DATA_W  = 32;

   localparam logic [REG_ADDR_W-1:0] MAC_LO_ADDR = 4'h0;
   localparam logic [REG_ADDR_W-1:0] MAC_HI_ADDR = 4'h4;
   localparam logic [47:0]           MAC_BCAST   = 48'hFFFF_FFFF_FFFF;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] tdata;
      logic [AXIS_KEEP_W-1:0] tkeep;
      logic                   tlast;
      logic [AXIS_USER_W-1:0] tuser;
      logic                   tvalid;
   } s_req_t;

   typedef struct packed {
      logic tready;
   } s_rsp_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic                  write;
      logic [REG_DATA_W-1:0] wdata;
      logic [3:0]            wstrb;
      logic                  valid;
   } reg_bus_req_t;

   typedef struct packed {
      logic [REG_DATA_W-1:0] rdata;
      logic                  error;
      logic                  ready;
   } reg_bus_rsp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } filt_state_e;

   function automatic logic [REG_DATA_W-1:0] merge_wstrb(
      input logic [REG_DATA_W-1:0] cur,
      input logic [REG_DATA_W-1:0] wdata,
      input logic [3:0]            wstrb
   );
      logic [REG_DATA_W-1:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_stream_bus_if.sv
// Bundle of ingress/egress stream and config-bus signals of the MAC filter.
interface axi_stream_bus_if;
   import axi_stream_bus_pkg::*;

   s_req_t       rx_req;
   s_rsp_t       rx_rsp;
   s_req_t       tx_req;
   s_rsp_t       tx_rsp;
   reg_bus_req_t reg_req;
   reg_bus_rsp_t reg_rsp;

   modport master (output rx_req, input rx_rsp, input tx_req, output tx_rsp,
                   output reg_req, input reg_rsp);
   modport slave  (input rx_req, output rx_rsp, output tx_req, input tx_rsp,
                   input reg_req, output reg_rsp);
   modport regs   (input reg_req, output reg_rsp);
endinterface

// File: rtl/axi_stream_bus_regs.sv
// MAC_LO / MAC_HI register file with byte strobes; the PROMISC bit (MAC_HI[16])
// exists only when AXIS_FILTER_PROMISC_EN is defined, otherwise it reads 0.
module axi_stream_bus_regs
   import axi_stream_bus_pkg::*;
#(
   parameter int REG_AW = REG_ADDR_W
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   axi_stream_bus_if.regs reg_bus,
   output logic [47:0]    mac_o,
   output logic           promisc_o
);

   logic [REG_AW-1:0] addr;
   logic              hit_lo, hit_hi, wr_en;
   logic [31:0]       mac_lo_q, mac_lo_d;
   logic [15:0]       mac_hi_q, mac_hi_d;
   logic [31:0]       hi_word;
   reg_bus_rsp_t      rsp;

   assign addr   = reg_bus.reg_req.addr;
   assign hit_lo = (addr == MAC_LO_ADDR);
   assign hit_hi = (addr == MAC_HI_ADDR);
   assign wr_en  = reg_bus.reg_req.valid & reg_bus.reg_req.write;

`ifdef AXIS_FILTER_PROMISC_EN
   logic promisc_q, promisc_d;

   assign hi_word   = {15'd0, promisc_q, mac_hi_q};
   assign promisc_o = promisc_q;

   always_comb begin
      promisc_d = promisc_q;
      if (wr_en && hit_hi && reg_bus.reg_req.wstrb[2]) promisc_d = reg_bus.reg_req.wdata[16];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) promisc_q <= 1'b0;
      else         promisc_q <= promisc_d;
   end
`else
   assign hi_word   = {16'd0, mac_hi_q};
   assign promisc_o = 1'b0;
`endif

   always_comb begin
      mac_lo_d = mac_lo_q;
      mac_hi_d = mac_hi_q;
      if (wr_en && hit_lo) begin
         mac_lo_d = merge_wstrb(mac_lo_q, reg_bus.reg_req.wdata, reg_bus.reg_req.wstrb);
      end
      if (wr_en && hit_hi) begin
         if (reg_bus.reg_req.wstrb[0]) mac_hi_d[7:0]  = reg_bus.reg_req.wdata[7:0];
         if (reg_bus.reg_req.wstrb[1]) mac_hi_d[15:8] = reg_bus.reg_req.wdata[15:8];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mac_lo_q <= '0;
         mac_hi_q <= '0;
      end else begin
         mac_lo_q <= mac_lo_d;
         mac_hi_q <= mac_hi_d;
      end
   end

   // Read path is purely combinational; unmapped addresses read 0 and flag error.
   always_comb begin
      rsp       = '0;
      rsp.ready = 1'b1;
      if (hit_lo)      rsp.rdata = mac_lo_q;
      else if (hit_hi) rsp.rdata = hi_word;
      else             rsp.error = reg_bus.reg_req.valid;
   end

   assign reg_bus.reg_rsp = rsp;
   assign mac_o           = {mac_hi_q, mac_lo_q};

endmodule

// File: rtl/axi_stream_bus.sv
// Zero-latency destination-MAC filter on an AXI-Stream; promiscuous mode is
// compiled in only with AXIS_FILTER_PROMISC_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a first beat; accept decided on that beat
// ST_PASS | frame accepted, beats forwarded until tlast handshake
// ST_DROP | frame rejected, beats sunk until tlast beat
module axi_stream_bus
   import axi_stream_bus_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DATA_W,
   parameter int USER_WIDTH = AXIS_USER_W,
   parameter int REG_AW     = REG_ADDR_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  s_req_t       rx_axis_req_i,
   output s_rsp_t       rx_axis_rsp_o,
   output s_req_t       tx_axis_req_o,
   input  s_rsp_t       tx_axis_rsp_i,
   input  reg_bus_req_t reg_req_i,
   output reg_bus_rsp_t reg_rsp_o
);

   axi_stream_bus_if u_bus ();

   logic [47:0]             mac;
   logic                    promisc;
   logic                    run_q, run_d;
   filt_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0]   rx_tdata;
   logic [DATA_WIDTH/8-1:0] rx_tkeep;
   logic [USER_WIDTH-1:0]   rx_tuser;
   logic                    rx_valid, rx_last, tx_ready;
   logic                    rx_ready, fwd, accept;
   logic [47:0]             dst_mac;
   s_req_t                  tx_req;
   s_rsp_t                  rx_rsp;

   assign u_bus.rx_req  = rx_axis_req_i;
   assign u_bus.tx_rsp  = tx_axis_rsp_i;
   assign u_bus.reg_req = reg_req_i;
   assign u_bus.rx_rsp  = rx_rsp;
   assign u_bus.tx_req  = tx_req;
   assign rx_axis_rsp_o = u_bus.rx_rsp;
   assign tx_axis_req_o = u_bus.tx_req;
   assign reg_rsp_o     = u_bus.reg_rsp;

   axi_stream_bus_regs #(.REG_AW(REG_AW)) u_regs (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .reg_bus   (u_bus),
      .mac_o     (mac),
      .promisc_o (promisc)
   );

   assign rx_tdata = u_bus.rx_req.tdata;
   assign rx_tkeep = u_bus.rx_req.tkeep;
   assign rx_tuser = u_bus.rx_req.tuser;
   assign rx_valid = u_bus.rx_req.tvalid;
   assign rx_last  = u_bus.rx_req.tlast;
   assign tx_ready = u_bus.tx_rsp.tready;

   assign dst_mac = rx_tdata[47:0];
   assign accept  = (dst_mac == mac) || (dst_mac == MAC_BCAST) || dst_mac[40] || promisc;

   // run_q holds both handshakes low from reset assertion until the first edge after release.
   assign run_d = 1'b1;

   always_comb begin
      state_d  = state_q;
      fwd      = 1'b0;
      rx_ready = 1'b0;
      if (run_q) begin
         case (state_q)
            ST_IDLE: begin
               fwd      = accept;
               rx_ready = accept ? tx_ready : 1'b1;
               if (rx_valid && rx_ready && !rx_last) state_d = accept ? ST_PASS : ST_DROP;
            end
            ST_PASS: begin
               fwd      = 1'b1;
               rx_ready = tx_ready;
               if (rx_valid && rx_ready && rx_last) state_d = ST_IDLE;
            end
            ST_DROP: begin
               rx_ready = 1'b1;
               if (rx_valid && rx_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
      end
   end

   always_comb begin
      tx_req        = '0;
      tx_req.tdata  = rx_tdata;
      tx_req.tkeep  = rx_tkeep;
      tx_req.tlast  = rx_last;
      tx_req.tuser  = rx_tuser;
      tx_req.tvalid = rx_valid & fwd;
      rx_rsp        = '0;
      rx_rsp.tready = rx_ready;
   end

endmodule

// File: tb/tb_axi_stream_bus.sv
// Directed bench for axi_stream_bus: register vector table plus frame sequences
// (match/broadcast/multicast/drop, promisc, mid-frame config, stalls, reset abort).
module tb_axi_stream_bus;
   import axi_stream_bus_pkg::*;

`ifdef AXIS_FILTER_PROMISC_EN
   localparam bit PROMISC_EN = 1'b1;
`else
   localparam bit PROMISC_EN = 1'b0;
`endif

   localparam logic [63:0] BEAT_UNI   = 64'h1032_2070_9800_1032;
   localparam logic [63:0] BEAT_BCAST = 64'h1032_FFFF_FFFF_FFFF;
   localparam logic [63:0] BEAT_MCAST = 64'h1032_0100_5EFF_FFFF;
   localparam logic [63:0] BEAT_MISS  = 64'h1032_0001_5EFF_3FFF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_stream_bus_if bus_if ();

   axi_stream_bus dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .rx_axis_req_i (bus_if.rx_req),
      .rx_axis_rsp_o (bus_if.rx_rsp),
      .tx_axis_req_o (bus_if.tx_req),
      .tx_axis_rsp_i (bus_if.tx_rsp),
      .reg_req_i     (bus_if.reg_req),
      .reg_rsp_o     (bus_if.reg_rsp)
   );

   typedef struct {
      logic [3:0]  addr;
      bit          wr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } reg_vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          frame_id = 0;
   bit          stall_mode = 1'b0;
   int          stall_left = 0;
   logic [72:0] exp_q[$];
   logic [72:0] got_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_tready();
      if (!stall_mode) begin
         bus_if.tx_rsp.tready = 1'b1;
      end else if (stall_left > 0) begin
         bus_if.tx_rsp.tready = 1'b0;
         stall_left--;
      end else begin
         bus_if.tx_rsp.tready = 1'b1;
         if ($urandom_range(0, 3) == 0) stall_left = $urandom_range(0, 50);
      end
   endtask

   task automatic reg_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      @(posedge clk); #1;
      bus_if.reg_req = '{addr: a, write: 1'b1, wdata: d, wstrb: s, valid: 1'b1};
      @(posedge clk); #1;
      bus_if.reg_req.valid = 1'b0;
      bus_if.reg_req.write = 1'b0;
   endtask

   task automatic reg_read_check(input string name, input logic [3:0] a,
                                 input logic [31:0] exp_d, input bit exp_e);
      @(posedge clk); #1;
      bus_if.reg_req = '{addr: a, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
      @(negedge clk);
      check({name, " rdata"}, 64'(bus_if.reg_rsp.rdata), 64'(exp_d));
      check({name, " error"}, 64'(bus_if.reg_rsp.error), 64'(exp_e));
      check({name, " ready"}, 64'(bus_if.reg_rsp.ready), 64'd1);
      bus_if.reg_req.valid = 1'b0;
   endtask

   task automatic send_frame(input string name, input logic [63:0] beat0, input int nbeats,
                             input bit exp_pass, input bit term, input int wr_beat,
                             input logic [3:0] wr_addr, input logic [31:0] wr_data,
                             output int stalls);
      logic [63:0] d;
      logic [7:0]  kp;
      logic        lst;
      int          guard;
      stalls = 0;
      for (int k = 0; k < nbeats; k++) begin
         d   = (k == 0) ? beat0 : (64'hC0DE_0000_0000_0000 | (64'(frame_id) << 32) | 64'(k));
         lst = term && (k == nbeats - 1);
         kp  = lst ? 8'h0F : 8'hFF;
         @(posedge clk); #1;
         bus_if.rx_req.tdata  = d;
         bus_if.rx_req.tkeep  = kp;
         bus_if.rx_req.tlast  = lst;
         bus_if.rx_req.tuser  = '0;
         bus_if.rx_req.tvalid = 1'b1;
         drive_tready();
         if (k == wr_beat) begin
            bus_if.reg_req = '{addr: wr_addr, write: 1'b1, wdata: wr_data, wstrb: 4'hF, valid: 1'b1};
         end else begin
            bus_if.reg_req.valid = 1'b0;
            bus_if.reg_req.write = 1'b0;
         end
         @(negedge clk);
         guard = 0;
         while (!bus_if.rx_rsp.tready && guard < 200) begin
            stalls++;
            guard++;
            @(posedge clk); #1;
            drive_tready();
            bus_if.reg_req.valid = 1'b0;
            bus_if.reg_req.write = 1'b0;
            @(negedge clk);
         end
         if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s beat %0d: ingress tready low for %0d cycles, expected handshake", name, k, guard);
            return;
         end
         if (exp_pass) exp_q.push_back({d, kp, lst});
      end
      frame_id++;
   endtask

   task automatic frame(input string name, input logic [63:0] beat0, input int nbeats,
                        input bit exp_pass, input bit chk_nostall);
      int st;
      send_frame(name, beat0, nbeats, exp_pass, 1'b1, -1, 4'h0, 32'h0, st);
      if (chk_nostall) check({name, " ingress stalls"}, 64'(st), 64'd0);
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      bus_if.rx_req.tvalid = 1'b0;
      bus_if.tx_rsp.tready = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   task automatic check_sb(input string name);
      check({name, " egress count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s beat%0d tdata", name, i), got_q[i][72:9], exp_q[i][72:9]);
         check($sformatf("%s beat%0d keep/last", name, i), 64'(got_q[i][8:0]), 64'(exp_q[i][8:0]));
      end
      exp_q.delete();
      got_q.delete();
   endtask

   // Egress monitor: collects handshaken beats and checks that stalled beats are held.
   initial begin
      logic        prev_v;
      logic        prev_r;
      logic [63:0] prev_d;
      prev_v = 1'b0;
      prev_r = 1'b1;
      prev_d = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (prev_v && !prev_r) begin
               check("hold tvalid", 64'(bus_if.tx_req.tvalid), 64'd1);
               check("hold tdata", bus_if.tx_req.tdata, prev_d);
            end
            if (bus_if.tx_req.tvalid && bus_if.tx_rsp.tready)
               got_q.push_back({bus_if.tx_req.tdata, bus_if.tx_req.tkeep, bus_if.tx_req.tlast});
         end
         prev_v = bus_if.tx_req.tvalid;
         prev_r = bus_if.tx_rsp.tready;
         prev_d = bus_if.tx_req.tdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reg_vec_t rv [10];
      int       st;

      rv[0] = '{4'h0, 1'b1, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};
      rv[1] = '{4'h0, 1'b1, 32'h11223344, 4'h5, 32'hDE22BE44, 1'b0};
      rv[2] = '{4'h8, 1'b1, 32'h12345678, 4'hF, 32'h00000000, 1'b1};
      rv[3] = '{4'h0, 1'b0, 32'h00000000, 4'h0, 32'hDE22BE44, 1'b0};
      rv[4] = '{4'h4, 1'b1, 32'hFFFFFFFF, 4'hF, PROMISC_EN ? 32'h0001FFFF : 32'h0000FFFF, 1'b0};
      rv[5] = '{4'h4, 1'b1, 32'h00000000, 4'h4, 32'h0000FFFF, 1'b0};
      rv[6] = '{4'h4, 1'b1, 32'h00AB0000, 4'h2, 32'h000000FF, 1'b0};
      rv[7] = '{4'hC, 1'b0, 32'h00000000, 4'h0, 32'h00000000, 1'b1};
      rv[8] = '{4'h0, 1'b1, 32'h98001032, 4'hF, 32'h98001032, 1'b0};
      rv[9] = '{4'h4, 1'b1, 32'h00002070, 4'hF, 32'h00002070, 1'b0};

      bus_if.rx_req  = '{tdata: BEAT_UNI, tkeep: 8'hFF, tlast: 1'b0, tuser: '0, tvalid: 1'b1};
      bus_if.tx_rsp  = '{tready: 1'b1};
      bus_if.reg_req = '{addr: 4'h0, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};

      #12;
      check("reset tx tvalid", 64'(bus_if.tx_req.tvalid), 64'd0);
      check("reset rx tready", 64'(bus_if.rx_rsp.tready), 64'd0);
      check("reset mac_lo", 64'(bus_if.reg_rsp.rdata), 64'd0);
      bus_if.reg_req.addr = 4'h4;
      #1;
      check("reset mac_hi", 64'(bus_if.reg_rsp.rdata), 64'd0);
      bus_if.rx_req.tvalid = 1'b0;
      bus_if.reg_req.valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         if (rv[i].wr) reg_write(rv[i].addr, rv[i].wdata, rv[i].wstrb);
         reg_read_check($sformatf("reg[%0d]", i), rv[i].addr, rv[i].exp_rdata, rv[i].exp_err);
      end

      // Back-to-back frames, no egress stalls.
      frame("unicast", BEAT_UNI, 8, 1'b1, 1'b1);
      frame("bcast", BEAT_BCAST, 8, 1'b1, 1'b1);
      frame("mcast", BEAT_MCAST, 8, 1'b1, 1'b1);
      frame("miss", BEAT_MISS, 8, 1'b0, 1'b1);
      frame("after miss", BEAT_UNI, 8, 1'b1, 1'b1);
      idle(3);
      check_sb("b2b");

      reg_write(4'h4, 32'h00012070, 4'hF);
      reg_read_check("promisc rd", 4'h4, PROMISC_EN ? 32'h00012070 : 32'h00002070, 1'b0);
      frame("promisc miss", BEAT_MISS, 8, PROMISC_EN, 1'b1);
      idle(2);
      check_sb("promisc");
      reg_write(4'h4, 32'h00002070, 4'hF);

      // MAC rewritten mid-frame: current frame unaffected, next one uses new MAC.
      send_frame("midcfg", BEAT_UNI, 8, 1'b1, 1'b1, 3, 4'h0, 32'h0000_0000, st);
      check("midcfg ingress stalls", 64'(st), 64'd0);
      frame("midcfg next", BEAT_UNI, 8, 1'b0, 1'b1);
      idle(2);
      check_sb("midcfg");
      reg_write(4'h0, 32'h98001032, 4'hF);

      frame("single miss", BEAT_MISS, 1, 1'b0, 1'b1);
      frame("single uni", BEAT_UNI, 1, 1'b1, 1'b1);
      frame("short miss", BEAT_MISS, 3, 1'b0, 1'b1);
      frame("short bcast", BEAT_BCAST, 2, 1'b1, 1'b1);
      idle(2);
      check_sb("short");

      // Random egress stalls; dropped frames must never stall ingress.
      stall_mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         case (i % 3)
            0: frame($sformatf("stall uni%0d", i), BEAT_UNI, 6, 1'b1, 1'b0);
            1: frame($sformatf("stall miss%0d", i), BEAT_MISS, 4, 1'b0, 1'b1);
            default: frame($sformatf("stall mcast%0d", i), BEAT_MCAST, 5, 1'b1, 1'b0);
         endcase
      end
      stall_mode = 1'b0;
      stall_left = 0;
      idle(3);
      check_sb("stall");
      reg_read_check("unmapped 0x8", 4'h8, 32'h0, 1'b1);

      // Reset in the middle of a dropped frame aborts it.
      send_frame("abort", BEAT_MISS, 3, 1'b0, 1'b0, -1, 4'h0, 32'h0, st);
      check("abort ingress stalls", 64'(st), 64'd0);
      @(posedge clk); #1;
      bus_if.rx_req.tdata  = 64'h1234_0000_0000_0000;
      bus_if.rx_req.tlast  = 1'b0;
      bus_if.rx_req.tvalid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst tx tvalid", 64'(bus_if.tx_req.tvalid), 64'd0);
      check("midrst rx tready", 64'(bus_if.rx_rsp.tready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus_if.rx_req.tvalid = 1'b0;
      reg_read_check("post-rst mac_lo", 4'h0, 32'h0, 1'b0);
      reg_read_check("post-rst mac_hi", 4'h4, 32'h0, 1'b0);
      frame("post-rst first", 64'h1234_0000_0000_0000, 1, 1'b1, 1'b1);
      idle(3);
      check_sb("rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
